ecc_scalar_feeder: RTL and testbench

Supplies the secret scalar, one bit per request, to the ECC point-multiplication controller during the Montgomery ladder. It sits between the register interface, which writes the 384-bit scalar as 32-bit words, and the controller, which raises `req_digit` once per ladder step and samples `digit` for the key-dependent operand swap. It is the responder on the controller's `req_digit`/`digit` interface, and it owns scalar storage, bit ordering, request counting and the protocol-error flag.

---
 rtl/ecc_scalar_pkg.sv | 26 ++
 rtl/ecc_scalar_store.sv | 34 +++
 rtl/ecc_scalar_feeder.sv | 117 +++++++++++
 tb/tb_ecc_scalar_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scalar_pkg.sv
// Shared constants, state encoding and write payload for the ECC scalar feeder.
package ecc_scalar_pkg;

  localparam int unsigned SCALAR_W  = 384;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = SCALAR_W / WORD_W;
  localparam int unsigned IDX_W     = 9;
  localparam int unsigned WADDR_W   = 4;

  // Bit index of the first digit served (MSB first).
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SCALAR_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One word write into scalar storage.
  typedef struct packed {
    logic               we;
    logic [WADDR_W-1:0] addr;
    logic [WORD_W-1:0]  data;
  } scalar_wr_t;

endpackage

// File: rtl/ecc_scalar_store.sv
// Scalar storage: 12 x 32-bit words written by index, read one bit at a time.
module ecc_scalar_store
  import ecc_scalar_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  scalar_wr_t       wr_i,
  input  logic             zeroize_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic             bit_c_o
);

  // Flat image: word w occupies bits [w*WORD_W +: WORD_W].
  logic [SCALAR_W-1:0] scalar_q;

  // Word writes; zeroize wins, indices >= NUM_WORDS match no word and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scalar_q <= '0;
    end else if (zeroize_i) begin
      scalar_q <= '0;
    end else if (wr_i.we) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        if (wr_i.addr == WADDR_W'(w)) begin
          scalar_q[w*WORD_W +: WORD_W] <= wr_i.data;
        end
      end
    end
  end

  // Bit-select read of the current scalar image.
  assign bit_c_o = scalar_q[sel_i];

endmodule

// File: rtl/ecc_scalar_feeder.sv
// ECC scalar feeder: serves the stored 384-bit scalar MSB first, one bit per
// rising edge of req_digit_i, and flags protocol errors.
// Option ECC_SCALAR_ZEROIZE_EN: clear scalar storage on entry to DONE.
module ecc_scalar_feeder
  import ecc_scalar_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scalar_we_i,
  input  logic [WADDR_W-1:0] scalar_waddr_i,
  input  logic [WORD_W-1:0]  scalar_wdata_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               req_digit_i,
  output logic               digit_o,
  output logic               ready_o,
  output logic               done_o,
  output logic               err_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             digit_q, digit_d;
  logic             err_q, err_d;
  logic             req_q;
  logic             ready_q, done_q;

  logic             req_edge_c;
  logic             zeroize_c;
  logic             rd_bit_c;
  scalar_wr_t       wr_c;

  // A held request level counts once: only the rising edge is a request.
  assign req_edge_c = req_digit_i & ~req_q;

  ecc_scalar_store u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_i     (wr_c),
    .zeroize_i(zeroize_c),
    .sel_i    (idx_q),
    .bit_c_o  (rd_bit_c)
  );

  // Next-state, digit, error and storage-control decode in priority order.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    err_d     = err_q;
    zeroize_c = 1'b0;
    wr_c.we   = scalar_we_i & ~clear_i & (state_q != ARMED);
    wr_c.addr = scalar_waddr_i;
    wr_c.data = scalar_wdata_i;

    if (clear_i) begin
      zeroize_c = 1'b1;
      idx_d     = IDX_TOP;
      digit_d   = 1'b0;
      err_d     = 1'b0;
      state_d   = IDLE;
    end else begin
      // Storage is frozen while digits are being served.
      if (scalar_we_i && (state_q == ARMED)) begin
        err_d = 1'b1;
      end
      if (start_i && (state_q != ARMED)) begin
        idx_d   = IDX_TOP;
        err_d   = 1'b0;
        state_d = ARMED;
      end else if (req_edge_c && !start_i) begin
        if (state_q == ARMED) begin
          digit_d = rd_bit_c;
          if (idx_q == '0) begin
            state_d = DONE;
`ifdef ECC_SCALAR_ZEROIZE_EN
            zeroize_c = 1'b1;
`else
            zeroize_c = 1'b0;
`endif
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State, digit, status and request-history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      digit_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      err_q   <= err_d;
      req_q   <= req_digit_i;
      ready_q <= (state_d == ARMED);
      done_q  <= (state_d == DONE);
    end
  end

  assign digit_o = digit_q;
  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ecc_scalar_feeder.sv
// Self-checking bench for ecc_scalar_feeder: per-cycle reference model plus
// directed literal checks and randomized runs.
module tb_ecc_scalar_feeder;

  localparam int SW = 384;
  localparam int WW = 32;
  localparam int NW = 12;
`ifdef ECC_SCALAR_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          scalar_we_i = 1'b0;
  logic [3:0]    scalar_waddr_i = '0;
  logic [WW-1:0] scalar_wdata_i = '0;
  logic          start_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          req_digit_i = 1'b0;
  logic          digit_o, ready_o, done_o, err_o;

  int checks = 0;
  int errors = 0;

  ecc_scalar_feeder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scalar_we_i   (scalar_we_i),
    .scalar_waddr_i(scalar_waddr_i),
    .scalar_wdata_i(scalar_wdata_i),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .req_digit_i   (req_digit_i),
    .digit_o       (digit_o),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  // Reference model: scalar image, digits served so far, mode, digit, error.
  bit [SW-1:0] m_scalar = '0;
  int          m_served = 0;
  int          m_mode = M_IDLE;
  bit          m_digit = 1'b0;
  bit          m_err = 1'b0;
  bit          m_req_prev = 1'b0;

  task automatic model_reset();
    m_scalar   = '0;
    m_served   = 0;
    m_mode     = M_IDLE;
    m_digit    = 1'b0;
    m_err      = 1'b0;
    m_req_prev = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    rise = req_digit_i && !m_req_prev;
    m_req_prev = req_digit_i;
    if (clear_i) begin
      m_scalar = '0;
      m_served = 0;
      m_digit  = 1'b0;
      m_err    = 1'b0;
      m_mode   = M_IDLE;
    end else begin
      if (scalar_we_i) begin
        if (m_mode == M_ARMED) m_err = 1'b1;
        else if (int'(scalar_waddr_i) < NW)
          m_scalar[int'(scalar_waddr_i)*WW +: WW] = scalar_wdata_i;
      end
      if (start_i && m_mode != M_ARMED) begin
        m_served = 0;
        m_err    = 1'b0;
        m_mode   = M_ARMED;
      end else if (rise && !start_i) begin
        if (m_mode == M_ARMED) begin
          m_digit  = m_scalar[SW-1-m_served];
          m_served = m_served + 1;
          if (m_served == SW) begin
            m_mode = M_DONE;
            if (ZEROIZE) m_scalar = '0;
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] act, exp;
    if (reset_n) begin
      act = {digit_o, ready_o, done_o, err_o};
      exp = {m_digit, (m_mode == M_ARMED), (m_mode == M_DONE), m_err};
      checks = checks + 1;
      if (act !== exp) begin
        errors = errors + 1;
        $display("FAIL cycle_cmp t=%0t {digit,ready,done,err} got=%b expected=%b", $time, act, exp);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [WW-1:0] data);
    scalar_we_i    = 1'b1;
    scalar_waddr_i = 4'(addr);
    scalar_wdata_i = data;
    tick();
    scalar_we_i = 1'b0;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  task automatic req_pulse(input int hold, input int gap);
    req_digit_i = 1'b1;
    repeat (hold) tick();
    req_digit_i = 1'b0;
    repeat (gap) tick();
  endtask

  // Serve n digits with single-cycle requests; report first, last and ones.
  task automatic run_digits(input int n, output int first, output int last, output int ones);
    ones = 0; first = 0; last = 0;
    for (int i = 0; i < n; i++) begin
      req_pulse(1, 1);
      if (i == 0) first = int'(digit_o);
      if (i == n - 1) last = int'(digit_o);
      ones = ones + int'(digit_o);
    end
  endtask

  task automatic load_random();
    for (int w = 0; w < NW; w++) write_word(w, WW'($urandom));
  endtask

  initial begin
    int first, last, ones;

    repeat (3) tick();
    chk("reset_outputs", int'({digit_o, ready_o, done_o, err_o}), 0);
    reset_n = 1'b1;
    tick();

    // MSB-first order.
    write_word(11, 32'h8000_0000);
    write_word(0, 32'h0000_0001);
    start_pulse();
    chk("t1_ready", int'(ready_o), 1);
    run_digits(SW, first, last, ones);
    chk("t1_first_digit", first, 1);
    chk("t1_last_digit", last, 1);
    chk("t1_ones", ones, 2);
    chk("t1_done", int'(done_o), 1);

    // Over-request.
    req_pulse(1, 1);
    chk("t3_err", int'(err_o), 1);
    chk("t3_digit_held", int'(digit_o), 1);
    chk("t3_done", int'(done_o), 1);

    // Restart without reload.
    start_pulse();
    chk("t6_err_cleared", int'(err_o), 0);
    run_digits(SW, first, last, ones);
    chk("t6_first", first, ZEROIZE ? 0 : 1);
    chk("t6_ones", ones, ZEROIZE ? 0 : 2);
    chk("t6_done", int'(done_o), 1);

    // Held request: one step only.
    for (int w = 0; w < NW - 1; w++) write_word(w, WW'($urandom));
    write_word(11, 32'hA000_0000 | (WW'($urandom) & 32'h0FFF_FFFF));
    start_pulse();
    req_pulse(1, 1);
    chk("t2_bit383", int'(digit_o), 1);
    req_digit_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("t2_hold_bit382", int'(digit_o), 0);
    end
    req_digit_i = 1'b0;
    tick();
    req_pulse(1, 1);
    chk("t2_bit381", int'(digit_o), 1);

    // Write while armed is dropped and flagged.
    write_word(11, 32'hFFFF_FFFF);
    tick();
    chk("t4_err", int'(err_o), 1);
    req_pulse(1, 1);
    chk("t4_bit380", int'(digit_o), 0);
    for (int i = 0; i < SW - 4; i++) req_pulse($urandom_range(1, 3), $urandom_range(1, 3));
    chk("t4_done", int'(done_o), 1);

    // Clear mid-run.
    load_random();
    start_pulse();
    for (int i = 0; i < 100; i++) req_pulse(1, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("t5_ready", int'(ready_o), 0);
    chk("t5_done", int'(done_o), 0);
    chk("t5_digit", int'(digit_o), 0);
    start_pulse();
    run_digits(SW, first, last, ones);
    chk("t5_ones_after_clear", ones, 0);

    // Randomized runs with protocol abuse, checked by the model.
    for (int run = 0; run < 4; run++) begin
      load_random();
      write_word($urandom_range(12, 15), WW'($urandom));
      if (run == 1) req_pulse(1, 1);
      start_pulse();
      for (int i = 0; i < SW + $urandom_range(0, 2); i++) begin
        int r;
        r = $urandom_range(0, 63);
        if (r == 0) begin
          start_i = 1'b1;
          req_digit_i = 1'b1;
          tick();
          start_i = 1'b0;
          req_digit_i = 1'b0;
          tick();
        end else if (r == 1) begin
          write_word($urandom_range(0, 11), WW'($urandom));
        end
        if (run == 2 && i == 150) begin
          reset_n = 1'b0;
          tick();
          reset_n = 1'b1;
          tick();
          start_pulse();
        end
        req_pulse($urandom_range(1, 4), $urandom_range(1, 3));
      end
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
